// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op/state encodings for the iterative RV32M divider
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - restoring divider, one quotient bit per cycle, register-file write-port outputs
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = div_unit_pkg::XLEN,
    parameter int CNT_W = div_unit_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wn,
    output logic            we
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [XLEN-1:0]   rem, rem_n;
    logic [XLEN-1:0]   quo, quo_n;
    logic [XLEN-1:0]   dvs, dvs_n;
    logic [1:0]        op_q, op_q_n;
    logic [4:0]        rd_q, rd_q_n;
    logic              qneg, qneg_n;
    logic              rneg, rneg_n;
    logic [XLEN-1:0]   result_n;
    logic [4:0]        wn_n;
    logic              done_n;
    logic              we_n;

    logic              sgn_in;
    logic              is_rem_in;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quo;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              last_step;

    assign busy = (state == CALC);

    assign sgn_in    = (op == OP_DIV) || (op == OP_REM);
    assign is_rem_in = (op == OP_REM) || (op == OP_REMU);
    assign div_zero  = (b == '0);
    assign overflow  = sgn_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign abs_a     = (sgn_in && a[XLEN-1]) ? -a : a;
    assign abs_b     = (sgn_in && b[XLEN-1]) ? -b : b;

    // Trial subtract is one bit wider so its borrow decides the quotient bit.
    assign rem_sh    = {rem, quo[XLEN-1]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign step_rem  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign step_quo  = {quo[XLEN-2:0], ~diff[XLEN]};
    assign quo_fix   = qneg ? -step_quo : step_quo;
    assign rem_fix   = rneg ? -step_rem : step_rem;
    assign last_step = (cnt == CNT_W'(XLEN-1));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        op_q_n   = op_q;
        rd_q_n   = rd_q;
        qneg_n   = qneg;
        rneg_n   = rneg;
        result_n = result;
        wn_n     = wn;
        done_n   = 1'b0;
        we_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !kill) begin
                    op_q_n = op;
                    rd_q_n = rd;
                    qneg_n = sgn_in && (a[XLEN-1] ^ b[XLEN-1]);
                    rneg_n = sgn_in && a[XLEN-1];
                    dvs_n  = abs_b;
                    quo_n  = abs_a;
                    rem_n  = '0;
                    cnt_n  = '0;
                    if (div_zero || overflow) begin
                        if (div_zero)
                            result_n = is_rem_in ? a : '1;
                        else
                            result_n = is_rem_in ? '0 : a;
                        wn_n   = rd;
                        done_n = 1'b1;
                        we_n   = (rd != 5'd0);
                    end else begin
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    rem_n = step_rem;
                    quo_n = step_quo;
                    cnt_n = cnt + CNT_W'(1);
                    if (last_step) begin
                        state_n  = IDLE;
                        cnt_n    = '0;
                        result_n = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
                        wn_n     = rd_q;
                        done_n   = 1'b1;
                        we_n     = (rd_q != 5'd0);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            result <= '0;
            wn     <= '0;
            done   <= 1'b0;
            we     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rem    <= rem_n;
            quo    <= quo_n;
            dvs    <= dvs_n;
            op_q   <= op_q_n;
            rd_q   <= rd_q_n;
            qneg   <= qneg_n;
            rneg   <= rneg_n;
            result <= result_n;
            wn     <= wn_n;
            done   <= done_n;
            we     <= we_n;
        end
    end

endmodule
